// File: rtl/i_cache.sv
// ---------------------------------------------------------------------------
// i_cache -- direct-mapped instruction cache, one 32-bit word per line.
//
// Hits are returned combinationally (zero latency). A miss latches the
// word-aligned fetch address and holds a line-fill request until the memory
// controller acknowledges. The acknowledged word is written into the line
// and, if the fetch stage is still asking for it, forwarded in the same
// cycle. Lookups to other lines keep hitting while a fill is outstanding.
//
// Optional feature macro: ICACHE_FLUSH_EN
//   When defined, a flush input invalidates every line. A flush that overlaps
//   an outstanding fill lets the request run to completion but discards the
//   returning word.
//
// Parameters:
//   INDEX_BITS      log2 of the line count (default 7 -> 128 lines)
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   addr[31:0]      fetch address (bits [1:0] ignored)
//   inst_available  inst is valid for addr this cycle
//   inst[31:0]      instruction word, 0 whenever inst_available is 0
//   mem_req         line-fill request to the memory controller
//   mem_addr[31:0]  word-aligned fill address
//   mem_ack         fill data valid on mem_data this cycle
//   mem_data[31:0]  fill word
//   flush           invalidate all lines (ICACHE_FLUSH_EN only)
// ---------------------------------------------------------------------------
module i_cache #(
  parameter int INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic        inst_available,
  output logic [31:0] inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic        flush
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic {
    IDLE,
    MISS
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  // Word address (addr[31:2]) of the outstanding miss.
  logic [29:0] miss_word_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_BITS-1:0]   miss_tag;
  logic                  hit;
  logic                  fwd;
  logic                  fill_we;
  logic                  drop_fill;   // returning word must not be used
  logic                  lookup_off;  // force inst_available low this cycle
  logic                  addr_unused;

  // Byte offset within the word plays no part in the lookup.
  assign addr_unused = ^addr[1:0];

  assign idx      = addr[INDEX_BITS+1:2];
  assign tag      = addr[31:INDEX_BITS+2];
  assign miss_idx = miss_word_q[INDEX_BITS-1:0];
  assign miss_tag = miss_word_q[29:INDEX_BITS];

  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

`ifdef ICACHE_FLUSH_EN
  // Set once a flush lands while a fill is outstanding, so the stale word
  // that eventually comes back is thrown away.
  logic discard_q;

  assign lookup_off = flush;
  assign drop_fill  = flush | discard_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      discard_q <= 1'b0;
    end else if (state_q == MISS && mem_ack) begin
      discard_q <= 1'b0;
    end else if (state_q == MISS && flush) begin
      discard_q <= 1'b1;
    end
  end
`else
  assign lookup_off = 1'b0;
  assign drop_fill  = 1'b0;
`endif

  // The ack cycle still completes the FSM handshake even when the word is
  // dropped; only the write and the forward are suppressed.
  assign fill_we = (state_q == MISS) && mem_ack && !rst && !drop_fill;
  assign fwd     = (state_q == MISS) && mem_ack && !drop_fill &&
                   (addr[31:2] == miss_word_q);

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers sample
    // the same pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      miss_word_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && !hit) begin
        miss_word_q <= addr[31:2];
      end
      if (fill_we) begin
        valid_q[miss_idx] <= 1'b1;
      end
`ifdef ICACHE_FLUSH_EN
      if (flush) begin
        valid_q <= '0;
      end
`endif
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves an output unassigned, which
    // would infer a latch.
    state_d = state_q;
    mem_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!hit) begin
          state_d = MISS;
        end
      end
      MISS: begin
        mem_req = !rst;
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Line storage
  // -------------------------------------------------------------------------
  // NOTE: tag and data arrays are deliberately not reset; the valid bits
  // alone decide whether a line is usable, and leaving the arrays out of the
  // reset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= mem_data;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign inst_available = !rst && !lookup_off && (hit || fwd);
  assign inst           = !inst_available ? 32'h0 :
                          hit             ? data_mem[idx] : mem_data;
  assign mem_addr       = rst ? 32'h0 : {miss_word_q, 2'b00};

endmodule

// File: tb/tb_i_cache.sv
// ---------------------------------------------------------------------------
// tb_i_cache -- directed self-checking bench for i_cache (INDEX_BITS = 7).
// Each scenario task drives stimulus and compares outputs inline; expected
// values are hand-computed constants. Define ICACHE_FLUSH_EN for both the
// RTL and this bench to include the flush scenario.
// ---------------------------------------------------------------------------
module tb_i_cache;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        inst_available;
  logic [31:0] inst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
`ifdef ICACHE_FLUSH_EN
  logic        flush;
`endif

  int total;
  int bad;

  i_cache #(.INDEX_BITS(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .inst_available(inst_available),
    .inst          (inst),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
`ifdef ICACHE_FLUSH_EN
    .flush         (flush),
`endif
    .mem_data      (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven and outputs
  // sampled well away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; addr = 32'h0000_1000; mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    tick();
    settle();
    total++; if (inst_available !== 1'b0) begin bad++; $display("FAIL reset_avail: got %b want 0", inst_available); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 00000000", inst); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr); end
    rst = 1'b0; mem_ack = 1'b0; mem_data = 32'h0;
  endtask

  task automatic test_miss_fill();
    addr = 32'h0000_1000;
    settle();
    total++; if (inst_available !== 1'b0) begin bad++; $display("FAIL first_miss_avail: got %b want 0", inst_available); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL first_miss_idle_req: got %b want 0", mem_req); end
    tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL miss_req: got %b want 1", mem_req); end
    total++; if (mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL miss_mem_addr: got %h want 00001000", mem_addr); end
    // Two more wait cycles (three total) with the request held.
    tick();
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL miss_hold: got req=%b addr=%h want req=1 addr=00001000", mem_req, mem_addr); end
    total++; if (inst !== 32'h0) begin bad++; $display("FAIL miss_inst_zero: got %h want 00000000", inst); end
    mem_ack = 1'b1; mem_data = 32'h0010_0093;
    settle();
    total++; if (inst_available !== 1'b1 || inst !== 32'h0010_0093) begin bad++; $display("FAIL fwd: got avail=%b inst=%h want 1 00100093", inst_available, inst); end
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    settle();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL post_ack_req: got %b want 0", mem_req); end
    total++; if (inst_available !== 1'b1 || inst !== 32'h0010_0093) begin bad++; $display("FAIL hit_1000: got avail=%b inst=%h want 1 00100093", inst_available, inst); end
    tick();
    total++; if (mem_req !== 1'b0 || inst !== 32'h0010_0093) begin bad++; $display("FAIL repeat_hit: got req=%b inst=%h want 0 00100093", mem_req, inst); end
  endtask

  task automatic test_replace();
    // Same index as 0x1000, different tag. An ack while idle is ignored.
    addr = 32'h0000_1200; mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    settle();
    total++; if (inst_available !== 1'b0 || inst !== 32'h0) begin bad++; $display("FAIL idle_ack_ignored: got avail=%b inst=%h want 0 00000000", inst_available, inst); end
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    settle();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1200) begin bad++; $display("FAIL replace_req: got req=%b addr=%h want 1 00001200", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = 32'h1111_1111;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    settle();
    total++; if (inst_available !== 1'b1 || inst !== 32'h1111_1111) begin bad++; $display("FAIL hit_1200: got avail=%b inst=%h want 1 11111111", inst_available, inst); end
    addr = 32'h0000_1000;
    settle();
    total++; if (inst_available !== 1'b0) begin bad++; $display("FAIL evicted_1000: got %b want 0", inst_available); end
    tick();
    total++; if (mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL refill_addr: got %h want 00001000", mem_addr); end
    mem_ack = 1'b1; mem_data = 32'h0010_0093;
    tick();
    // Cache 0x1004 (index 1) as well.
    mem_ack = 1'b0; addr = 32'h0000_1004;
    tick();
    mem_ack = 1'b1; mem_data = 32'h2222_2222;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    settle();
    total++; if (inst !== 32'h2222_2222) begin bad++; $display("FAIL hit_1004: got %h want 22222222", inst); end
  endtask

  task automatic test_hit_under_miss();
    addr = 32'h0000_2000;
    tick();
    addr = 32'h0000_1004;
    settle();
    total++; if (inst_available !== 1'b1 || inst !== 32'h2222_2222) begin bad++; $display("FAIL hum_hit: got avail=%b inst=%h want 1 22222222", inst_available, inst); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_2000) begin bad++; $display("FAIL hum_req: got req=%b addr=%h want 1 00002000", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = 32'h3333_3333;
    settle();
    total++; if (inst !== 32'h2222_2222) begin bad++; $display("FAIL hum_ack_inst: got %h want 22222222", inst); end
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    settle();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL hum_done_req: got %b want 0", mem_req); end
    addr = 32'h0000_2000;
    settle();
    total++; if (inst_available !== 1'b1 || inst !== 32'h3333_3333) begin bad++; $display("FAIL hum_filled: got avail=%b inst=%h want 1 33333333", inst_available, inst); end
    addr = 32'h0000_1000;
    settle();
    total++; if (inst_available !== 1'b0) begin bad++; $display("FAIL hum_evict_1000: got %b want 0", inst_available); end
    addr = 32'h0000_1004;
    settle();
    total++; if (inst !== 32'h2222_2222) begin bad++; $display("FAIL hum_kept_1004: got %h want 22222222", inst); end
  endtask

  task automatic test_back_to_back();
    // Miss on 0x3000, then move to another missing address mid-fill.
    addr = 32'h0000_3000;
    tick();
    addr = 32'h0000_4008;
    settle();
    total++; if (inst_available !== 1'b0 || mem_addr !== 32'h0000_3000) begin bad++; $display("FAIL b2b_hold: got avail=%b addr=%h want 0 00003000", inst_available, mem_addr); end
    mem_ack = 1'b1; mem_data = 32'h6666_6666;
    settle();
    total++; if (inst_available !== 1'b0) begin bad++; $display("FAIL b2b_no_fwd: got %b want 0", inst_available); end
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    settle();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap: got %b want 0", mem_req); end
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_4008) begin bad++; $display("FAIL b2b_second: got req=%b addr=%h want 1 00004008", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = 32'h7777_7777;
    settle();
    total++; if (inst !== 32'h7777_7777) begin bad++; $display("FAIL b2b_fwd: got %h want 77777777", inst); end
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    addr = 32'h0000_3000;
    settle();
    total++; if (inst_available !== 1'b1 || inst !== 32'h6666_6666) begin bad++; $display("FAIL b2b_3000: got avail=%b inst=%h want 1 66666666", inst_available, inst); end
  endtask

  task automatic test_reset_during_miss();
    addr = 32'h0000_2000;
    tick();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rdm_req: got %b want 1", mem_req); end
    rst = 1'b1; mem_ack = 1'b1; mem_data = 32'h4444_4444;
    settle();
    total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin bad++; $display("FAIL rdm_in_reset: got req=%b addr=%h want 0 00000000", mem_req, mem_addr); end
    total++; if (inst_available !== 1'b0 || inst !== 32'h0) begin bad++; $display("FAIL rdm_no_fwd: got avail=%b inst=%h want 0 00000000", inst_available, inst); end
    tick();
    rst = 1'b0; mem_ack = 1'b0; mem_data = 32'h0;
    settle();
    total++; if (inst_available !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL rdm_after: got avail=%b req=%b want 0 0", inst_available, mem_req); end
    addr = 32'h0000_3000;
    settle();
    total++; if (inst_available !== 1'b0) begin bad++; $display("FAIL rdm_valid_clear: got %b want 0", inst_available); end
    addr = 32'h0000_2000;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_2000) begin bad++; $display("FAIL rdm_remiss: got req=%b addr=%h want 1 00002000", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_data = 32'h8888_8888;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    settle();
    total++; if (inst !== 32'h8888_8888) begin bad++; $display("FAIL rdm_refill: got %h want 88888888", inst); end
  endtask

`ifdef ICACHE_FLUSH_EN
  task automatic test_flush();
    flush = 1'b1;
    settle();
    total++; if (inst_available !== 1'b0) begin bad++; $display("FAIL flush_avail: got %b want 0", inst_available); end
    tick();
    flush = 1'b0;
    settle();
    total++; if (inst_available !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL flush_miss: got avail=%b req=%b want 0 0", inst_available, mem_req); end
    tick();
    flush = 1'b1; mem_ack = 1'b1; mem_data = 32'h9999_9999;
    settle();
    total++; if (inst_available !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL flush_ack: got avail=%b req=%b want 0 1", inst_available, mem_req); end
    tick();
    flush = 1'b0; mem_ack = 1'b0; mem_data = 32'h0;
    settle();
    total++; if (inst_available !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL flush_discard: got avail=%b req=%b want 0 0", inst_available, mem_req); end
    tick();
    mem_ack = 1'b1; mem_data = 32'hAAAA_AAAA;
    tick();
    mem_ack = 1'b0; mem_data = 32'h0;
    settle();
    total++; if (inst !== 32'hAAAA_AAAA) begin bad++; $display("FAIL flush_refill: got %h want aaaaaaaa", inst); end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
`ifdef ICACHE_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_miss_fill();
    test_replace();
    test_hit_under_miss();
    test_back_to_back();
    test_reset_during_miss();
`ifdef ICACHE_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i_cache.md
I_CACHE -- requirements
Module: i_cache

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 7, giving the log2 of the line count (128 direct-mapped lines, one 32-bit word per line).
REQ-002 The block SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port addr  input  32  fetch address from the fetch stage; bits [1:0] ignored.
REQ-005 The block SHALL have port inst_available  output  1  inst is valid for addr this cycle.
REQ-006 The block SHALL have port inst  output  32  instruction word for addr.
REQ-007 The block SHALL have port mem_req  output  1  line-fill request to the memory controller.
REQ-008 The block SHALL have port mem_addr  output  32  word-aligned fill address, bits [1:0] = 0.
REQ-009 The block SHALL have port mem_ack  input  1  fill data valid on mem_data this cycle.
REQ-010 The block SHALL have port mem_data  input  32  fill word.
REQ-011 The block SHALL have port flush  input  1  invalidate all lines; present only when ICACHE_FLUSH_EN is defined.

Function
REQ-012 Address split SHALL be: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]; storage per line: valid bit, tag, 32-bit data.
REQ-013 Hit (valid[index] and tag match) SHALL be combinational: inst_available = 1 and inst = stored data in the same cycle, zero latency.
REQ-014 FSM states SHALL be IDLE and MISS only.
REQ-015 IDLE to MISS SHALL occur at the edge where addr misses and rst is low; miss address (word-aligned) latched into mem_addr at that edge.
REQ-016 In MISS, mem_req SHALL be 1 and mem_addr SHALL be held stable until mem_ack is sampled high.
REQ-017 On a MISS cycle with mem_ack = 1: the line at the latched index SHALL be written (valid = 1, tag, mem_data); the FSM SHALL return to IDLE; mem_req = 0 from the next cycle.
REQ-018 In the mem_ack cycle, if addr word-matches the latched miss address, the block SHALL forward: inst_available = 1, inst = mem_data.
REQ-019 If addr changes during MISS, the fill SHALL still complete for the latched address; the new addr is evaluated from IDLE afterwards (no request abort).
REQ-020 A hit on a different line during MISS SHALL return inst_available = 1 (hit-under-miss).
REQ-021 mem_ack SHALL be ignored while in IDLE.
REQ-022 Whenever inst_available = 0, inst SHALL be 32'h0.
REQ-023 A fill SHALL overwrite the indexed line regardless of its prior contents (direct-mapped replacement).

Reset
REQ-024 While rst = 1: inst_available = 0, inst = 0, mem_req = 0, mem_addr = 0.
REQ-025 At a rising edge with rst = 1, all valid bits SHALL clear and the FSM SHALL enter IDLE; data/tag arrays need not clear.
REQ-026 Reset during MISS SHALL abandon the fill: mem_req = 0 the cycle rst is high, and no line is written even if mem_ack = 1 in that cycle.

Configuration
REQ-027 With ICACHE_FLUSH_EN defined: flush = 1 at an edge SHALL clear all valid bits; inst_available = 0 in any cycle flush = 1 except the REQ-018 forward case, which is also suppressed.
REQ-028 With ICACHE_FLUSH_EN defined, flush during MISS SHALL not abort mem_req; the returning word SHALL be discarded (not written, not forwarded), including when flush and mem_ack coincide.
REQ-029 Without ICACHE_FLUSH_EN, the flush port and its logic SHALL be absent; valid bits clear only on reset.

Verification
REQ-030 Reset, then addr = 32'h0000_1000 -> inst_available = 0; next cycle mem_req = 1 with mem_addr = 32'h0000_1000.
REQ-031 mem_ack = 1 with mem_data = 32'h0010_0093 after 3 wait cycles -> inst_available = 1 and inst = 32'h0010_0093 in the ack cycle; mem_req = 0 on the next cycle; repeated addr hits with no request.
REQ-032 With 32'h0000_1000 cached, addr = 32'h0000_1200 (same index, different tag, INDEX_BITS = 7) -> miss and refill; 32'h0000_1000 then misses.
REQ-033 During MISS for 32'h0000_2000, switch addr to cached 32'h0000_1004 -> hit with inst_available = 1; the fill completes and writes 32'h0000_2000 only.
REQ-034 rst = 1 during MISS with mem_ack = 1 in the same cycle -> no line written; after reset, 32'h0000_2000 misses.
REQ-035 With ICACHE_FLUSH_EN defined, flush = 1 for one cycle after caching 32'h0000_1000 -> next access misses; flush coincident with mem_ack -> data discarded and the FSM returns to IDLE.
